// File: rtl/regfile_pkg.sv
// Shared constants for the ID-stage register file and its pending-write scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    // Default geometry: 32 x 32-bit registers, up to 3 in-flight writes per register.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_PEND_W = 2;

    // Hardwired-zero register address.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters with issue/write/flush arbitration and busy lookup.
// Latency: counter updates land at the next clk edge; issue_ready and lookups are combinational.
// Backpressure: issue_ready drops when issue_dst's counter is saturated and no same-cycle write frees a slot.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] lookupAddrA,
    input  logic [ADDR_W-1:0] lookupAddrB,
    output logic              issue_ready,
    output logic [PEND_W-1:0] pendCntA,
    output logic [PEND_W-1:0] pendCntB
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [PEND_W-1:0] CNT_MAX   = '1;

    logic [PEND_W-1:0] pendCnt [DEPTH];

    logic wrLive;
    logic issueWrHit;
    logic issueAcc;

    // Writes to the zero register never touch the scoreboard.
    assign wrLive     = we && (waddr != ZERO_ADDR);
    assign issueWrHit = wrLive && (waddr == issue_dst);

    // A saturated counter can still accept an issue when a write retires one slot this cycle.
    assign issue_ready = !((pendCnt[issue_dst] == CNT_MAX) && !issueWrHit);
    assign issueAcc    = issue_valid && issue_ready && (issue_dst != ZERO_ADDR);

    // Counter update: reset/flush clear all; issue+write on same register cancel; decrement never goes below 0.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                pendCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issueAcc && (issue_dst == ADDR_W'(i))) begin
                    if (!issueWrHit) begin
                        pendCnt[i] <= pendCnt[i] + PEND_W'(1);
                    end
                end else if (wrLive && (waddr == ADDR_W'(i)) && (pendCnt[i] != '0)) begin
                    pendCnt[i] <= pendCnt[i] - PEND_W'(1);
                end
            end
        end
    end

    assign pendCntA = (lookupAddrA == ZERO_ADDR) ? '0 : pendCnt[lookupAddrA];
    assign pendCntB = (lookupAddrB == ZERO_ADDR) ? '0 : pendCnt[lookupAddrB];

endmodule

// File: rtl/regfile_sb.sv
// ID-stage register file: 2 combinational reads, 1 writeback, zero reg, pending-write scoreboard, branch comparator.
// Latency: reads/compare 0 cycles; writes visible next cycle (same cycle when REGFILE_BYPASS_EN is defined).
// Backpressure: issue_ready from the scoreboard; rs_busy/rt_busy feed the hazard unit's stall decision.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              issue_ready,
    input  logic              flush,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              cmp_eq,
    output logic              cmp_lt
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regMem [DEPTH];
    logic [DATA_W-1:0] storRs;
    logic [DATA_W-1:0] storRt;
    logic [PEND_W-1:0] pendRs;
    logic [PEND_W-1:0] pendRt;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .waddr       (waddr),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .flush       (flush),
        .lookupAddrA (rs_addr),
        .lookupAddrB (rt_addr),
        .issue_ready (issue_ready),
        .pendCntA    (pendRs),
        .pendCntB    (pendRt)
    );

    // Storage: reset clears every entry; writes to the zero register are dropped. Flush leaves data alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regMem[i] <= '0;
            end
        end else if (we && (waddr != ZERO_ADDR)) begin
            regMem[waddr] <= wdata;
        end
    end

    assign storRs = (rs_addr == ZERO_ADDR) ? '0 : regMem[rs_addr];
    assign storRt = (rt_addr == ZERO_ADDR) ? '0 : regMem[rt_addr];

`ifdef REGFILE_BYPASS_EN
    logic fwdRs;
    logic fwdRt;

    // Same-cycle writeback forwards data and retires its pending slot from the busy view.
    assign fwdRs   = we && (waddr == rs_addr) && (rs_addr != ZERO_ADDR);
    assign fwdRt   = we && (waddr == rt_addr) && (rt_addr != ZERO_ADDR);
    assign rs_data = fwdRs ? wdata : storRs;
    assign rt_data = fwdRt ? wdata : storRt;
    assign rs_busy = (pendRs != '0) && !(fwdRs && (pendRs == PEND_W'(1)));
    assign rt_busy = (pendRt != '0) && !(fwdRt && (pendRt == PEND_W'(1)));
`else
    // Without forwarding, ID sees pre-write storage and registered counters only.
    assign rs_data = storRs;
    assign rt_data = storRt;
    assign rs_busy = (pendRs != '0);
    assign rt_busy = (pendRt != '0);
`endif

    // Branch resolution on the final (possibly forwarded) operands.
    assign cmp_eq = (rs_data == rt_data);
    assign cmp_lt = ($signed(rs_data) < $signed(rt_data));

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised + directed scoreboard bench for regfile_sb against a behavioural register/pending model.
// Latency: expected outputs are queued per cycle and checked by an independent monitor mid-cycle.
// Backpressure: issue_ready expectation derives from the in-flight count per register.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr, waddr, issue_dst;
    logic [31:0] rs_data, rt_data, wdata;
    logic        we, issue_valid, issue_ready, flush;
    logic        rs_busy, rt_busy, cmp_eq, cmp_lt;

    regfile_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .issue_ready (issue_ready),
        .flush       (flush),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .cmp_eq      (cmp_eq),
        .cmp_lt      (cmp_lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic        rsb;
        logic        rtb;
        logic        rdy;
        logic        eq;
        logic        lt;
    } exp_t;

    exp_t        expQ[$];
    int          total = 0;
    int          bad   = 0;

    // Reference model: architectural register values and number of writes still owed per register.
    logic [31:0] mReg  [32];
    int          mPend [32];
    localparam int MAX_PEND = 3;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive, queue the expected visible outputs, then advance the model past the edge.
    task automatic cyc(input bit r, input bit w, input int wa, input logic [31:0] wd,
                       input bit iv, input int id, input bit fl, input int ra, input int rb);
        exp_t e;
        bit   fa, fb, rdy, acc;
        int   pa, pb;
        @(negedge clk);
        #1;
        rst_n = r; we = w; waddr = 5'(wa); wdata = wd;
        issue_valid = iv; issue_dst = 5'(id); flush = fl;
        rs_addr = 5'(ra); rt_addr = 5'(rb);

        fa  = BYP && w && (wa == ra) && (ra != 0);
        fb  = BYP && w && (wa == rb) && (rb != 0);
        rdy = !(mPend[id] == MAX_PEND && !(w && wa == id && wa != 0));
        if (r) begin
            e.rs = fa ? wd : mReg[ra];
            e.rt = fb ? wd : mReg[rb];
            pa = mPend[ra] - ((fa && mPend[ra] > 0) ? 1 : 0);
            pb = mPend[rb] - ((fb && mPend[rb] > 0) ? 1 : 0);
            e.rsb = (pa != 0);
            e.rtb = (pb != 0);
            e.rdy = rdy;
            e.eq  = (e.rs == e.rt);
            e.lt  = ($signed(e.rs) < $signed(e.rt));
            expQ.push_back(e);
        end

        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                mReg[i] = '0;
                mPend[i] = 0;
            end
        end else begin
            if (w && wa != 0) mReg[wa] = wd;
            if (fl) begin
                for (int i = 0; i < 32; i++) mPend[i] = 0;
            end else begin
                acc = iv && rdy && (id != 0);
                if (!(acc && w && wa == id)) begin
                    if (acc) mPend[id]++;
                    if (w && wa != 0 && mPend[wa] > 0) mPend[wa]--;
                end
            end
        end
    endtask

    // Monitor: outputs are combinational, so each cycle with a queued expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("rs_data", rs_data, e.rs);
                chk("rt_data", rt_data, e.rt);
                chk("rs_busy", 32'(rs_busy), 32'(e.rsb));
                chk("rt_busy", 32'(rt_busy), 32'(e.rtb));
                chk("issue_ready", 32'(issue_ready), 32'(e.rdy));
                chk("cmp_eq", 32'(cmp_eq), 32'(e.eq));
                chk("cmp_lt", 32'(cmp_lt), 32'(e.lt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r, w, iv, fl;
        logic [31:0] wd;
        for (int i = 0; i < 32; i++) begin
            mReg[i] = '0;
            mPend[i] = 0;
        end
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; issue_valid = 1'b0;
        issue_dst = '0; flush = 1'b0; rs_addr = '0; rt_addr = '0;

        // Reset, then sweep every address on both ports.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 32'h55, 1, 3, 1, 0, 0);
        for (int a = 0; a < 32; a++) cyc(1, 0, 0, 0, 0, 0, 0, a, 31 - a);

        // Basic write/read and zero-register discard.
        cyc(1, 1, 8, 32'hDEADBEEF, 0, 0, 0, 8, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 8, 0);
        cyc(1, 1, 0, 32'h1234, 0, 0, 0, 0, 8);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 8);

        // Saturate r9, rejected 4th issue, then drain.
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1, 9, 0, 9, 0);
        cyc(1, 0, 0, 0, 1, 9, 0, 9, 0);
        cyc(1, 1, 9, 32'h99, 0, 9, 0, 9, 0);
        cyc(1, 0, 0, 0, 0, 9, 0, 9, 0);
        cyc(1, 1, 9, 32'h98, 0, 9, 0, 9, 9);
        cyc(1, 1, 9, 32'h97, 0, 9, 0, 9, 9);
        cyc(1, 0, 0, 0, 0, 9, 0, 9, 9);

        // Saturated r9 with same-cycle write still accepts the issue.
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1, 9, 0, 9, 0);
        cyc(1, 1, 9, 32'h96, 1, 9, 0, 9, 0);
        cyc(1, 0, 0, 0, 1, 9, 0, 9, 0);

        // Same-cycle issue and write on r10 with counter 1.
        cyc(1, 0, 0, 0, 1, 10, 0, 10, 0);
        cyc(1, 1, 10, 32'hA5A5, 1, 10, 0, 10, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 10, 0);

        // Signed compare with a write to rs in flight.
        cyc(1, 1, 6, 32'h1, 1, 5, 0, 0, 0);
        cyc(1, 1, 5, 32'h80000000, 0, 0, 0, 5, 6);
        cyc(1, 0, 0, 0, 0, 0, 0, 5, 6);
        cyc(1, 0, 0, 0, 0, 0, 0, 6, 5);

        // Flush with concurrent issue and write.
        cyc(1, 0, 0, 0, 1, 3, 0, 3, 4);
        cyc(1, 0, 0, 0, 1, 3, 0, 3, 4);
        cyc(1, 0, 0, 0, 1, 4, 0, 3, 4);
        cyc(1, 1, 4, 32'h44, 1, 3, 1, 3, 4);
        cyc(1, 0, 0, 0, 0, 3, 0, 3, 4);

        // Reset mid-sequence clears data and counters.
        cyc(1, 1, 7, 32'h77, 1, 7, 0, 7, 8);
        cyc(0, 1, 7, 32'h78, 1, 7, 0, 7, 8);
        cyc(1, 0, 0, 0, 0, 0, 0, 7, 8);

        // Random traffic on a narrow address window to force collisions.
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 99) != 0);
            w  = $urandom_range(0, 1);
            iv = $urandom_range(0, 1);
            fl = ($urandom_range(0, 19) == 0);
            wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            cyc(r, w, $urandom_range(0, 7), wd, iv, $urandom_range(0, 7), fl,
                $urandom_range(0, 7), $urandom_range(0, 7));
        end

        @(negedge clk);
        #5;
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised ID-stage register file for the pipelined processor: generalised data width and depth, two combinational read ports, one writeback port, a hardwired zero register, optional same-cycle write-to-read forwarding, and a per-register pending-write scoreboard. The block drives the hazard unit's stall decision. It also resolves branch conditions in ID through a built-in equality/signed-less-than comparator on the two read operands.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- PEND_W, 2, pending-write counter width; max in-flight writes per register = 2**PEND_W-1

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- rs_addr  input  ADDR_W  read port A address (instr[25:21] in 32-bit config)
- rt_addr  input  ADDR_W  read port B address (instr[20:16])
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- we  input  1  writeback enable (from WB)
- waddr  input  ADDR_W  writeback destination (RegDst already resolved upstream)
- wdata  input  DATA_W  writeback data
- issue_valid  input  1  an instruction leaving ID will write issue_dst
- issue_dst  input  ADDR_W  destination of issuing instruction
- issue_ready  output  1  issue accepted this cycle
- flush  input  1  clear all pending counters (branch mispredict/squash)
- rs_busy  output  1  rs_addr has an outstanding write
- rt_busy  output  1  rt_addr has an outstanding write
- cmp_eq  output  1  rs_data == rt_data
- cmp_lt  output  1  rs_data < rt_data, signed

## Operation
- Storage: 2**ADDR_W x DATA_W. Register 0 always reads 0. Writes to it are discarded. It is never busy, and issues to it do not change any counter.
- Write: on posedge clk with rst_n=1, we=1, waddr!=0: reg[waddr] <= wdata.
- Read: rs_data/rt_data are combinational from storage, plus forwarding when enabled (see Configuration).
- Scoreboard: one PEND_W-bit counter per register.
  - Accepted issue (issue_valid && issue_ready && issue_dst!=0) increments the counter of issue_dst.
  - A write with we=1 to a register with a nonzero counter decrements that counter.
  - A write to a register whose counter is 0 updates data and leaves the counter at 0.
  - Issue and write to the same register in the same cycle: counter unchanged.
- issue_ready = 0 only when the counter of issue_dst is at its maximum and there is no same-cycle write to issue_dst. A rejected issue changes nothing.
- rs_busy/rt_busy = counter of the addressed register is nonzero. Register 0 is never busy.
- flush=1: all counters go to 0 at the next edge; register data is untouched. A write in the same cycle still updates data. A simultaneous issue is ignored.
- Comparator: cmp_eq/cmp_lt are pure functions of the final rs_data/rt_data, including forwarding.

## Timing
- Reset (rst_n=0 at posedge): all registers 0, all counters 0.
  - Following outputs: rs_data=rt_data=0, rs_busy=rt_busy=0, issue_ready=1, cmp_eq=1, cmp_lt=0.
  - Reset overrides we, issue_valid and flush in the same cycle.
- Read latency 0 cycles (combinational). Write visible on read ports the cycle after the write edge, or the same cycle with forwarding.
- Counter updates take effect at the next posedge. Busy outputs reflect registered counters, adjusted by the same-cycle write when forwarding is enabled.
- Counters never wrap: increment is blocked by issue_ready, and decrement at 0 is suppressed.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If we=1 and waddr==rs_addr!=0, rs_data = wdata in the same cycle; likewise for rt.
  - rs_busy/rt_busy are computed from the counter minus the pending same-cycle decrement, so a final outstanding write clears busy combinationally.
- REGFILE_BYPASS_EN undefined:
  - Reads return pre-write storage contents, and busy uses registered counters only.
  - ID must stall one extra cycle on a WB-to-ID dependency.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W/PEND_W constants, ZERO_REG address constant.
- Sub-module regfile_scoreboard: counter array, issue/write/flush arbitration, issue_ready, and raw busy lookup for two addresses. Top instantiates it alongside the storage array and comparator.

## Test plan
- Reset, then read all addresses -> every rs_data/rt_data = 0, busy=0, issue_ready=1, cmp_eq=1.
- Write 0xDEADBEEF to r8, read rs=8/rt=0 next cycle -> rs_data=0xDEADBEEF, rt_data=0, cmp_eq=0. Write 0x1234 to r0 -> r0 still reads 0.
- Issue r9 three times (PEND_W=2) -> issue_ready drops to 0 for a 4th issue to r9. Write r9 once -> counter 2, issue_ready=1. Three total writes -> rs_busy(9)=0.
- Same-cycle issue and write to r10 with counter 1 -> counter stays 1, r10 data updated.
- Bypass build: write r5=0x80000000 while rs=5, rt=6 (r6=1) -> same cycle rs_data=0x80000000, cmp_lt=1. Non-bypass build: rs_data shows old r5 until next cycle.
- Counters nonzero on r3/r4, assert flush with issue r3 -> next cycle all busy=0, r3 counter 0. rst_n low mid-sequence -> all state cleared next edge.
